// File: rtl/value_change_recorder_pkg.sv
// Shared definitions for the value change recorder: FSM state encodings and
// record field offsets within rd_data = {lost, timestamp, mask, value}.
package value_change_recorder_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SNAP = 2'd1,
        ST_ON   = 2'd2
    } vcr_state_e;

    function automatic int unsigned vcr_rec_width(input int unsigned nsig, input int unsigned tw);
        return tw + 2 * nsig + 1;
    endfunction

    function automatic int unsigned vcr_value_ofs(input int unsigned nsig);
        return 0 * nsig;
    endfunction

    function automatic int unsigned vcr_mask_ofs(input int unsigned nsig);
        return nsig;
    endfunction

    function automatic int unsigned vcr_ts_ofs(input int unsigned nsig);
        return 2 * nsig;
    endfunction

    function automatic int unsigned vcr_lost_ofs(input int unsigned nsig, input int unsigned tw);
        return 2 * nsig + tw;
    endfunction

endpackage

// File: rtl/vcr_fifo.sv
// Synchronous first-word-fall-through FIFO for change records. Head is visible
// on dout whenever not empty; dout reads as zero while empty.
module vcr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign empty     = (count_r == LW'(0));
    assign full      = (count_r == LW'(DEPTH));
    assign level     = count_r;
    // A pop on a full FIFO frees the slot the same edge, so the push may proceed.
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Head-of-queue presentation, forced to zero when nothing is stored.
    always_comb begin
        dout = '0;
        if (!empty) begin
            dout = mem_r[rd_ptr_r];
        end else begin
            dout = '0;
        end
    end

    // Record storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/value_change_recorder.sv
// Waveform capture stage: emits timestamped change records and a full snapshot
// on each enable. Optional sticky lost flag under macro VCR_LOST_FLAG_EN.
module value_change_recorder
    import value_change_recorder_pkg::*;
#(
    parameter int NSIG  = 8,
    parameter int TW    = 32,
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rec_en,
    input  logic [NSIG-1:0]             sig_in,
    input  logic                        rd_en,
    output logic                        rd_valid,
    output logic [TW+2*NSIG:0]          rd_data,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      level,
    output logic [DW-1:0]               drop_cnt
);

    localparam int RW       = vcr_rec_width(NSIG, TW);
    localparam int VAL_OFS  = vcr_value_ofs(NSIG);
    localparam int MASK_OFS = vcr_mask_ofs(NSIG);
    localparam int TS_OFS   = vcr_ts_ofs(NSIG);
    localparam int LOST_OFS = vcr_lost_ofs(NSIG, TW);

    vcr_state_e       state_r;
    vcr_state_e       state_s;
    logic [TW-1:0]    ts_r;
    logic [NSIG-1:0]  last_r;
    logic [DW-1:0]    drop_cnt_r;
    logic             want_s;
    logic             is_change_s;
    logic [NSIG-1:0]  mask_s;
    logic             accept_s;
    logic             drop_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_s;
    logic             lost_s;
    logic [RW-1:0]    rec_s;

    assign pop_s    = rd_en && !empty_s;
    assign accept_s = want_s && (!full_s || pop_s);
    // Only change records are ever counted as lost; snapshots retry instead.
    assign drop_s   = want_s && is_change_s && !accept_s;

`ifdef VCR_LOST_FLAG_EN
    logic lost_r;

    // Sticky loss marker, handed to the next record that makes it in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_r <= 1'b0;
        end else if (drop_s) begin
            lost_r <= 1'b1;
        end else if (accept_s) begin
            lost_r <= 1'b0;
        end
    end

    assign lost_s = lost_r;
`else
    assign lost_s = 1'b0;
`endif

    // Record write decision and next state.
    always_comb begin
        state_s     = state_r;
        want_s      = 1'b0;
        is_change_s = 1'b0;
        mask_s      = '0;
        case (state_r)
            ST_OFF, ST_SNAP: begin
                if (rec_en) begin
                    want_s  = 1'b1;
                    mask_s  = '1;
                    state_s = accept_s ? ST_ON : ST_SNAP;
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_ON: begin
                if (!rec_en) begin
                    state_s = ST_OFF;
                end else if (sig_in != last_r) begin
                    want_s      = 1'b1;
                    is_change_s = 1'b1;
                    mask_s      = sig_in ^ last_r;
                end else begin
                    state_s = ST_ON;
                end
            end
            default: begin
                state_s = ST_OFF;
            end
        endcase
    end

    // Record packing.
    always_comb begin
        rec_s                            = '0;
        rec_s[VAL_OFS +: NSIG]           = sig_in;
        rec_s[MASK_OFS +: NSIG]          = mask_s;
        rec_s[TS_OFS +: TW]              = ts_r;
        rec_s[LOST_OFS]                  = lost_s;
    end

    // Timestamp, previous sample, FSM state and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r       <= '0;
            last_r     <= '0;
            state_r    <= ST_OFF;
            drop_cnt_r <= '0;
        end else begin
            ts_r    <= ts_r + TW'(1);
            last_r  <= sig_in;
            state_r <= state_s;
            if (drop_s && (drop_cnt_r != {DW{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + DW'(1);
            end
        end
    end

    vcr_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept_s),
        .din   (rec_s),
        .pop   (pop_s),
        .dout  (rd_data),
        .empty (empty_s),
        .full  (full_s),
        .level (level)
    );

    assign rd_valid = !empty_s;
    assign full     = full_s;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_value_change_recorder.sv
// Scoreboard bench for value_change_recorder; follows VCR_LOST_FLAG_EN if defined.
module tb_value_change_recorder;

    localparam int NSIG  = 8;
    localparam int TW    = 32;
    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int RW    = TW + 2 * NSIG + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rec_en;
    logic [NSIG-1:0] sig_in;
    logic            rd_en;
    logic            rd_valid;
    logic [RW-1:0]   rd_data;
    logic            full;
    logic [4:0]      level;
    logic [DW-1:0]   drop_cnt;

    value_change_recorder #(.NSIG(NSIG), .TW(TW), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rec_en   (rec_en),
        .sig_in   (sig_in),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .full     (full),
        .level    (level),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [RW-1:0]   exp_q[$];
    int              m_state;
    logic [TW-1:0]   m_ts;
    logic [NSIG-1:0] m_last;
    int              m_drop;
    bit              m_lost;
    logic [NSIG-1:0] s;
    logic [DW-1:0]   drop_save;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = 0;
        m_ts    = '0;
        m_last  = '0;
        m_drop  = 0;
        m_lost  = 1'b0;
    endtask

    // Drive one cycle: check outputs against the scoreboard, advance the model, clock.
    task automatic cycle(input bit re, input logic [NSIG-1:0] si, input bit rd);
        bit want, chg, acc, pop, fullm, lbit;
        int nst;
        logic [NSIG-1:0] mask;
        logic [RW-1:0] rec;
        rec_en = re;
        sig_in = si;
        rd_en  = rd;
        check("rd_valid", rd_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("rd_data", rd_data, exp_q[0]);
        else                   check("rd_data_idle", rd_data, 64'd0);
        check("level", level, exp_q.size());
        check("full", full, exp_q.size() == DEPTH);
        check("drop_cnt", drop_cnt, m_drop);

        pop   = rd && (exp_q.size() != 0);
        fullm = (exp_q.size() == DEPTH);
        want  = 1'b0;
        chg   = 1'b0;
        mask  = '0;
        nst   = m_state;
        if (m_state == 0 || m_state == 1) begin
            if (re) begin
                want = 1'b1;
                mask = '1;
            end else begin
                nst = 0;
            end
        end else begin
            if (!re) nst = 0;
            else if (si != m_last) begin
                want = 1'b1;
                chg  = 1'b1;
                mask = si ^ m_last;
            end
        end
        acc = want && (!fullm || pop);
        if (want && !chg) nst = acc ? 2 : 1;
`ifdef VCR_LOST_FLAG_EN
        lbit = m_lost;
`else
        lbit = 1'b0;
`endif
        rec = {lbit, m_ts, mask, si};
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(rec);
            m_lost = 1'b0;
        end
        if (want && chg && !acc) begin
            if (m_drop < (1 << DW) - 1) m_drop++;
            m_lost = 1'b1;
        end
        m_ts    = m_ts + 32'd1;
        m_last  = si;
        m_state = nst;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        rec_en = 1'b0;
        sig_in = '0;
        rd_en  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", rd_valid, 64'd0);
        check("reset_data", rd_data, 64'd0);
        check("reset_level", level, 64'd0);
        check("reset_drop", drop_cnt, 64'd0);
        rst_n = 1'b1;

        // First snapshot at timestamp 3.
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h5A, 1'b0);
        cycle(1'b1, 8'h5A, 1'b0);
        check("snap_first", rd_data, {1'b0, 32'd3, 8'hFF, 8'h5A});
        check("snap_valid", rd_valid, 64'd1);

        // Toggle bit 0 for four cycles.
        s = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            s = s ^ 8'h01;
            cycle(1'b1, s, 1'b0);
        end
        check("toggle_level", level, 64'd5);

        // Fill, then three drops.
        for (int i = 0; i < 14; i++) begin
            s = s + 8'd1;
            cycle(1'b1, s, 1'b0);
        end
        check("fill_full", full, 64'd1);
        check("fill_level", level, 64'd16);
        check("fill_drop", drop_cnt, 64'd3);

        // Change while full with a simultaneous pop.
        s = s + 8'd1;
        cycle(1'b1, s, 1'b1);
        check("fullpop_level", level, 64'd16);
        check("fullpop_drop", drop_cnt, 64'd3);

        for (int i = 0; i < 20; i++) cycle(1'b1, s, 1'b1);
        check("drain_level", level, 64'd0);

        // Off for ten cycles while signals move, then re-enable.
        for (int i = 0; i < 10; i++) begin
            s = s + 8'd3;
            cycle(1'b0, s, 1'b0);
        end
        check("off_level", level, 64'd0);
        cycle(1'b1, 8'h3C, 1'b0);
        check("reen_level", level, 64'd1);
        check("reen_mask_val", rd_data[15:0], 64'hFF3C);
        check("reen_lost", rd_data[RW-1], 64'd0);

        // Snapshot retry while full; changes in SNAP must not count as drops.
        s = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            s = s + 8'd1;
            cycle(1'b1, s, 1'b0);
        end
        cycle(1'b0, s, 1'b0);
        drop_save = drop_cnt;
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        check("snap_nodrop", drop_cnt, drop_save);
        cycle(1'b1, 8'h33, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'h33, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 9) != 0), 8'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
        end

        // Mid-stream reset.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i * 7), 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_valid", rd_valid, 64'd0);
        check("rst_full", full, 64'd0);
        check("rst_level", level, 64'd0);
        check("rst_drop", drop_cnt, 64'd0);
        check("rst_data", rd_data, 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'hA5, 1'b0);
        check("rst_restart", rd_data, {1'b0, 32'd0, 8'hFF, 8'hA5});
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA5, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/value_change_recorder.md
Name: value_change_recorder

Overview:
- Capture stage for waveform recording: watches NSIG design signals every clock and turns each cycle with a value change into a timestamped change record.
- Records are queued in an internal first-word-fall-through FIFO and drained by a downstream dump writer.
- Recording is gated on/off at run time. Each switch-on emits a full snapshot record, so the dump is self-contained after a gap.

Parameters:
- NSIG, 8, number of monitored signals
- TW, 32, timestamp counter width
- DEPTH, 16, FIFO depth in records (power of two, >=2)
- DW, 16, drop-counter width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rec_en  input  1  recording enable (level)
- sig_in  input  NSIG  monitored signals, synchronous to clk
- rd_en  input  1  pop request from consumer
- rd_valid  output  1  head record valid (FIFO not empty)
- rd_data  output  TW+2*NSIG+1  {lost, timestamp[TW-1:0], mask[NSIG-1:0], value[NSIG-1:0]}
- full  output  1  FIFO full
- level  output  clog2(DEPTH)+1  records stored
- drop_cnt  output  DW  records dropped since reset, saturating

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - ts_q=0, last_q=0, state=OFF, FIFO empty.
  - rd_valid=0, full=0, level=0, drop_cnt=0, rd_data=0.
- Timestamp: ts_q increments every edge, wraps modulo 2^TW. A record carries ts_q as sampled at its write edge.
- last_q<=sig_in on every edge in every state.
- State machine, evaluated at each edge:
  - OFF, rec_en=0: stay OFF, no write.
  - OFF, rec_en=1: attempt snapshot write {mask=all ones, value=sig_in}. Accepted -> ON; not accepted -> SNAP.
  - SNAP, rec_en=0: -> OFF; pending snapshot abandoned, not counted as a drop.
  - SNAP, rec_en=1: retry the snapshot with the current sig_in. Change records are suppressed while in SNAP.
  - ON, rec_en=0: -> OFF, no record.
  - ON, rec_en=1 and sig_in!=last_q: attempt change write {mask=sig_in^last_q, value=sig_in}.
  - ON, no change: no write.
- Write acceptance: accepted if !full, or if a pop occurs the same edge (rd_en && rd_valid).
- Dropped writes:
  - A rejected change record increments drop_cnt, saturating at 2^DW-1.
  - A rejected snapshot retries instead of dropping.
- FIFO read side:
  - Operates as FWFT: rd_data shows the head whenever rd_valid=1.
  - rd_en with rd_valid=0 is ignored.
- Latency: a change at sig_in sampled at edge N gives rd_valid=1 and the record at the head in the cycle after edge N, if the FIFO was empty.
- Simultaneous push and pop on an empty FIFO: no bypass; only the push takes effect.
- level = writes minus pops. full = (level==DEPTH).
- Reset mid-operation: all state clears immediately; queued records are lost.

Optional Feature:
- Macro VCR_LOST_FLAG_EN.
- Defined:
  - A sticky lost_q sets on any dropped change record.
  - The next accepted record carries lost=1, and lost_q clears on that accept.
- Undefined:
  - The lost bit is tied 0.
  - drop_cnt behaves identically in both builds.

Decomposition:
- Shared include vcr_defs.vh:
  - state encodings (OFF=0, SNAP=1, ON=2)
  - rd_data field offset/width macros (lost, timestamp, mask, value)
- Sub-module vcr_fifo: parameterised synchronous FWFT FIFO providing push, pop, full, empty and level.

Test Plan:
- Reset, rec_en=1 at cycle 3 with sig_in=8'h5A -> one record {lost=0, ts=3, mask=8'hFF, value=8'h5A}, state ON.
- In ON, toggle sig_in bit0 every cycle for 4 cycles -> 4 records, mask=8'h01, consecutive timestamps, values alternating.
- Fill the FIFO with rd_en=0, then 3 more changes -> full=1, level=16, drop_cnt=3. With the macro, the first record after one pop has lost=1.
- Full FIFO with a change and rd_en=1 on the same edge -> record accepted, level stays 16, drop_cnt unchanged.
- rec_en 1->0 for 10 cycles while sig_in changes, then 0->1 -> no records while off; exactly one snapshot with the current value on re-enable.
- Assert rst_n low mid-stream for 2 cycles -> all outputs 0 immediately; ts restarts at 0 after release.
